fmul: RTL and testbench

FMUL -- requirements
Module: fmul

---
 rtl/fmul_pkg.sv | 15 +
 rtl/fmul_if.sv | 7 +
 rtl/fmul.sv | 42 ++++
 tb/tb_fmul.sv | 79 +++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// fmul_pkg: shared binary32 field layout, special encodings and operand classification for FPU blocks.
package fmul_pkg;
  localparam int WIDTH = 32;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [WIDTH-1:0] QNAN = 32'h7FC0_0000;
  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} fclass_e;
  // Denormals classify as zero: this FPU flushes them on input.
  function automatic fclass_e classify(input logic [WIDTH-1:0] v);
    return v[30:23] == EXP_MAX ? (v[22:0] != '0 ? CL_NAN : CL_INF) :
           v[30:23] == '0      ? CL_ZERO : CL_NORM;
  endfunction
endpackage

// File: rtl/fmul_if.sv
// fmul_if: operand/result bundle for the single-cycle binary32 multiplier.
interface fmul_if import fmul_pkg::*;;
  logic [WIDTH-1:0] x1, x2, y;
  logic rstn;
  modport master (output x1, x2, rstn, input y);
  modport slave (input x1, x2, rstn, output y);
endinterface

// File: rtl/fmul.sv
// fmul: binary32 multiplier, RNE rounding, flush-to-zero, one registered output stage.
module fmul import fmul_pkg::*; (
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] y,
  input  logic clk,
  input  logic rstn
);
  fclass_e c1, c2;
  logic sgn, norm, g, st, rnd, nan, inf, zero, inf_zero;
  logic [47:0] prod;
  logic [22:0] fr;
  logic [23:0] sig;
  logic signed [9:0] ex;
  logic [WIDTH-1:0] res, y_d, y_q;
  always_comb begin
    c1 = classify(x1);
    c2 = classify(x2);
    sgn = x1[31] ^ x2[31];
    prod = {1'b1, x1[22:0]} * {1'b1, x2[22:0]};
    norm = prod[47];
    fr = norm ? prod[46:24] : prod[45:23];
    g = norm ? prod[23] : prod[22];
    st = norm ? |prod[22:0] : |prod[21:0];
    rnd = g & (st | fr[0]);
    sig = {1'b0, fr} + {23'd0, rnd};
    // sig[23] is the rounding carry; the fraction bits are already zero in that case.
    ex = $signed({2'b00, x1[30:23]}) + $signed({2'b00, x2[30:23]}) - $signed(10'(BIAS))
       + $signed({9'd0, norm}) + $signed({9'd0, sig[23]});
    res = ex <= 10'sd0   ? {sgn, 31'd0} :
          ex >= 10'sd255 ? {sgn, EXP_MAX, 23'd0} : {sgn, ex[7:0], sig[22:0]};
    nan = c1 == CL_NAN || c2 == CL_NAN;
    inf = c1 == CL_INF || c2 == CL_INF;
    zero = c1 == CL_ZERO || c2 == CL_ZERO;
    inf_zero = inf && zero;
    y_d = nan || inf_zero ? QNAN :
          inf  ? {sgn, EXP_MAX, 23'd0} :
          zero ? {sgn, 31'd0} : res;
  end
  always_ff @(posedge clk) y_q <= rstn ? y_d : '0;
  assign y = y_q;
endmodule

// File: tb/tb_fmul.sv
// tb_fmul: directed and random checks of fmul against constants and a double-precision reference.
module tb_fmul;
  logic clk = 1'b0;
  int checks = 0, failures = 0;
  typedef struct { logic [31:0] exp; string tag; } ent_t;
  ent_t sb[$];
  fmul_if bus();
  fmul dut (.x1(bus.x1), .x2(bus.x2), .y(bus.y), .clk(clk), .rstn(bus.rstn));
  always #5 clk = ~clk;
  // Significand product is exact in double (48 < 53 bits); rounding to 23 bits done on the double's fraction.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    logic [63:0] pb;
    logic [23:0] t;
    int e;
    logic s;
    s = a[31] ^ b[31];
    ra = $bitstoreal({1'b0, 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
    rb = $bitstoreal({1'b0, 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
    pb = $realtobits(ra * rb);
    e = int'(pb[62:52]) - 896;
    t = {1'b0, pb[51:29]} + ((pb[28] && (|pb[27:0] || pb[29])) ? 24'd1 : 24'd0);
    if (t[23]) e++;
    return e <= 0 ? {s, 31'd0} : e >= 255 ? {s, 8'hFF, 23'd0} : {s, 8'(e), t[22:0]};
  endfunction
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic r,
                      input logic [31:0] exp, input string tag);
    ent_t e;
    bus.x1 = a;
    bus.x2 = b;
    bus.rstn = r;
    sb.push_back('{exp, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (bus.y === e.exp) else begin
      failures++;
      $error("FAIL %s y=%h expected=%h", e.tag, bus.y, e.exp);
    end
  endtask
  initial begin
    logic [31:0] a, b;
    bus.x1 = '0;
    bus.x2 = '0;
    bus.rstn = 1'b0;
    @(negedge clk);
    step(32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, "reset");
    step(32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000, "one_x_one");
    step(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, "two_x_three");
    step(32'hBFC00000, 32'h40000000, 1'b1, 32'hC0400000, "neg_1p5_x_2");
    step(32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, "round_ulp");
    step(32'h3FC00000, 32'h3F800001, 1'b1, 32'h3FC00002, "tie_odd_up");
    step(32'h3FC00000, 32'h3F800003, 1'b1, 32'h3FC00004, "tie_even_keep");
    step(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 32'h407FFFFE, "max_frac_sq");
    step(32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000, "overflow");
    step(32'hFF000000, 32'h7F000000, 1'b1, 32'hFF800000, "neg_overflow");
    step(32'h00800000, 32'h00800000, 1'b1, 32'h00000000, "underflow");
    step(32'h80800000, 32'h00800000, 1'b1, 32'h80000000, "neg_underflow");
    step(32'h80000000, 32'h3F800000, 1'b1, 32'h80000000, "neg_zero");
    step(32'h007FFFFF, 32'h3F800000, 1'b1, 32'h00000000, "denorm_in");
    step(32'h807FFFFF, 32'h7F800000, 1'b1, 32'h7FC00000, "denorm_x_inf");
    step(32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000, "inf_x_zero");
    step(32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000, "nan_in");
    step(32'h3F800000, 32'hFF800001, 1'b1, 32'h7FC00000, "neg_nan_in");
    step(32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, "neg_inf");
    step(32'hFF800000, 32'hFF800000, 1'b1, 32'h7F800000, "inf_x_inf");
    step(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, "pre_reset");
    step(32'h40000000, 32'h40400000, 1'b0, 32'h00000000, "mid_reset");
    step(32'hBFC00000, 32'h40000000, 1'b1, 32'hC0400000, "post_reset");
    for (int i = 0; i < 1000; i++) begin
      a = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      step(a, b, 1'b1, ref_mul(a, b), "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
